// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-divider helper,
// common to uart_rx_fifo and uart_tx_fifo.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HI
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers and a registered read port:
// a pop accepted on one edge presents its data with rd_valid on the next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ok,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  // A full FIFO still takes a write when the same edge frees a slot.
  assign do_pop  = rd_en && !empty;
  assign wr_ok   = !full || do_pop;
  assign do_push = wr_en && wr_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr  <= rd_ptr + (AW+1)'(1);
        rd_data <= mem[rd_ptr[AW-1:0]];
      end
      rd_valid <= do_pop;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronises i_rxp, decodes LSB-first frames by mid-bit
// sampling and buffers good bytes in a sync_fifo drained by rd_en/rd_valid.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_rxp,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_meta;
  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             push;
  logic             ferr_d;
  logic             wr_ok;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rxp;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    ferr_d     = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        baud_cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        if (baud_cnt_q == HALF_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d         = '0;
          shreg_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught.
        if (baud_cnt_q == BIT_LAST) begin
          baud_cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_HI;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      RX_WAIT_HI: begin
        if (rx_s) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RX_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      frame_err  <= ferr_d;
      overrun    <= push && !wr_ok;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (shreg_q),
    .wr_ok    (wr_ok),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial frames are generated directly,
// a queue model predicts FIFO contents, and a monitor checks every rd_valid.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 16;
  localparam int CLKS     = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_rxp = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int bad = 0;
  int mon_ferr = 0;
  int mon_ovr = 0;
  int exp_ferr = 0;
  int exp_ovr = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rxp     (i_rxp),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: pulse counters and scoreboard comparison on every read strobe.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err) mon_ferr++;
        if (overrun) mon_ovr++;
        if (rd_valid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rd_unexpected actual=0x%02h required=no_read", rd_data);
          end else begin
            e = exp_q.pop_front();
            if (rd_data !== e) begin
              bad++;
              $display("FAIL rd_data actual=0x%02h required=0x%02h", rd_data, e);
            end
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    i_rxp = 1'b0;
    repeat (CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rxp = b[i];
      repeat (CLKS) @(negedge clk);
    end
    i_rxp = stop;
    repeat (CLKS) @(negedge clk);
    i_rxp = 1'b1;
    if (!stop) repeat (2 * CLKS) @(negedge clk);
  endtask

  // Reference model: a good frame enters the FIFO unless it already holds DEPTH bytes.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_byte(b, stop);
    if (!stop) exp_ferr++;
    else if (model_q.size() < DEPTH) model_q.push_back(b);
    else exp_ovr++;
  endtask

  task automatic read_one();
    @(negedge clk);
    rd_en = 1'b1;
    if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic drain(input string name);
    while (model_q.size() > 0) read_one();
    repeat (3) @(negedge clk);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_empty"}, empty, 1);
    check({name, "_count"}, count, 0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_rd_data"}, rd_data, 0);
    check({name, "_rd_valid"}, rd_valid, 0);
    check({name, "_empty"}, empty, 1);
    check({name, "_full"}, full, 0);
    check({name, "_count"}, count, 0);
    check({name, "_frame_err"}, frame_err, 0);
    check({name, "_overrun"}, overrun, 0);
  endtask

  initial begin
    logic [7:0] prev;
    logic [7:0] b;
    int rv;
    int nf;
    int nr;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Loopback-style ordered bytes
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    check("t1_count", count, 4);
    drain("t1");

    // Short low glitch shorter than half a bit
    @(negedge clk);
    i_rxp = 1'b0;
    repeat (CLKS / 4) @(negedge clk);
    i_rxp = 1'b1;
    repeat (3 * CLKS) @(negedge clk);
    check("t2_count", count, 0);
    check("t2_ferr", mon_ferr, exp_ferr);

    // Framing error then a good frame
    send_frame(8'hA5, 1'b0);
    check("t3_ferr", mon_ferr, 1);
    check("t3_count", count, 0);
    send_frame(8'h5A, 1'b1);
    check("t3_count_good", count, 1);
    drain("t3");

    // Overrun: 17 frames with no reads
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    check("t4_full", full, 1);
    check("t4_count", count, 16);
    check("t4_overrun", mon_ovr, 1);
    drain("t4");

    // rd_en held across empty, then a push arrives
    prev = rd_data;
    @(negedge clk);
    rd_en = 1'b1;
    rv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rd_valid) rv++;
    end
    check("t5_no_valid_on_empty", rv, 0);
    check("t5_rd_data_held", rd_data, prev);
    exp_q.push_back(8'h7E);
    fork
      send_byte(8'h7E, 1'b1);
      begin : t5_watch
        int n;
        n = 0;
        @(negedge clk);
        while (empty && n < 20 * CLKS) begin
          @(negedge clk);
          n++;
        end
        check("t5_empty_fell", empty, 0);
        check("t5_valid_not_early", rd_valid, 0);
        @(negedge clk);
        check("t5_rd_valid", rd_valid, 1);
        check("t5_rd_data", rd_data, 8'h7E);
      end
    join
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_empty", empty, 1);

    // Reset during data bit 3 with a byte already buffered
    send_frame(8'h11, 1'b1);
    check("t6_pre_count", count, 1);
    fork
      send_byte(8'hF8, 1'b1);
      begin
        repeat (4 * CLKS + CLKS / 4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("t6_reset");
        model_q.delete();
        exp_q.delete();
        rst = 1'b0;
      end
    join
    repeat (2 * CLKS) @(negedge clk);
    check("t6_after_abort_count", count, 0);
    send_frame(8'h3C, 1'b1);
    check("t6_count", count, 1);
    drain("t6");

    // Randomised frames, framing errors, gaps and partial drains
    for (int r = 0; r < 8; r++) begin
      nf = $urandom_range(1, 5);
      for (int k = 0; k < nf; k++) begin
        b = 8'($urandom);
        send_frame(b, ($urandom_range(0, 5) != 0));
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      check("rnd_count", count, model_q.size());
      check("rnd_full", full, int'(model_q.size() == DEPTH));
      nr = $urandom_range(0, 6);
      repeat (nr) read_one();
    end
    drain("rnd");
    check("final_ferr", mon_ferr, exp_ferr);
    check("final_ovr", mon_ovr, exp_ovr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
